// File: rtl/ysyx_041461_hazard_scoreboard.sv
// rtl/ysyx_041461_hazard_scoreboard.sv - write-back scoreboard and ID issue interlock
module ysyx_041461_hazard_scoreboard #(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_wen,
    input  logic        id_csr_rd,
    input  logic        id_csr_wen,
    input  logic        exe_ready,
    input  logic        wb_commit,
    input  logic [4:0]  wb_rd,
    input  logic        wb_wen,
    input  logic        wb_csr_wen,
    input  logic        flush,
    output logic        id_stall,
    output logic        id_issue,
    output logic [1:0]  stall_reason,
    output logic [31:0] stall_cycles,
    output logic        sb_err
);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0] MAX_V = IW'(MAX_INFLIGHT);

    // Entry 0 is held at zero so x0 never looks pending.
    logic [CNT_W-1:0] cnt [0:31];
    logic [CNT_W-1:0] csr_cnt;
    logic [IW-1:0]    inflight;

    logic        raw_hz, csr_hz, struct_hz, hazard;
    logic        gpr_miss, commit_err;
    logic        csr_dec, inf_dec;
    logic [31:1] gpr_inc, gpr_dec;

    assign raw_hz = (id_use_rs1 & (id_rs1 != 5'd0) & (cnt[id_rs1] != '0)) |
                    (id_use_rs2 & (id_rs2 != 5'd0) & (cnt[id_rs2] != '0));
    assign csr_hz = (id_csr_rd | id_csr_wen) & (csr_cnt != '0);
    assign struct_hz = (inflight == MAX_V) |
                       (id_wen & (id_rd != 5'd0) & (&cnt[id_rd]));
    assign hazard = raw_hz | csr_hz | struct_hz;

    assign id_stall = rst | flush | (id_valid & hazard);
    assign id_issue = id_valid & ~id_stall & exe_ready;

    always_comb begin
        stall_reason = 2'd0;
        if (!rst && id_valid) begin
            if (raw_hz)         stall_reason = 2'd1;
            else if (csr_hz)    stall_reason = 2'd2;
            else if (struct_hz) stall_reason = 2'd3;
        end
    end

    // Decrements only apply to non-zero counters; a miss is flagged instead.
    always_comb begin
        gpr_inc = '0;
        gpr_dec = '0;
        for (int i = 1; i < 32; i++) begin
            gpr_inc[i] = id_issue & id_wen & (id_rd == 5'(i));
            gpr_dec[i] = wb_commit & wb_wen & (wb_rd == 5'(i)) & (cnt[i] != '0);
        end
    end

    assign csr_dec    = wb_commit & wb_csr_wen & (csr_cnt != '0);
    assign inf_dec    = wb_commit & (inflight != '0);
    assign gpr_miss   = wb_wen & (wb_rd != 5'd0) & (cnt[wb_rd] == '0);
    assign commit_err = wb_commit & (gpr_miss | (wb_csr_wen & (csr_cnt == '0)) |
                                     (inflight == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) cnt[i] <= '0;
            csr_cnt      <= '0;
            inflight     <= '0;
            stall_cycles <= '0;
            sb_err       <= 1'b0;
        end else begin
            if (id_valid & id_stall) stall_cycles <= stall_cycles + 32'd1;
            cnt[0] <= '0;
            if (flush) begin
                for (int i = 1; i < 32; i++) cnt[i] <= '0;
                csr_cnt  <= '0;
                inflight <= '0;
            end else begin
                if (commit_err) sb_err <= 1'b1;
                for (int i = 1; i < 32; i++)
                    cnt[i] <= cnt[i] + CNT_W'(gpr_inc[i]) - CNT_W'(gpr_dec[i]);
                csr_cnt  <= csr_cnt + CNT_W'(id_issue & id_csr_wen) - CNT_W'(csr_dec);
                inflight <= inflight + IW'(id_issue) - IW'(inf_dec);
            end
        end
    end
endmodule

// File: tb/tb_ysyx_041461_hazard_scoreboard.sv
// tb/tb_ysyx_041461_hazard_scoreboard.sv - directed and random checks against a behavioural scoreboard model
module tb_ysyx_041461_hazard_scoreboard;
    localparam int CNT_W = 2;
    localparam int MAX_INFLIGHT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid, id_use_rs1, id_use_rs2, id_wen, id_csr_rd, id_csr_wen, exe_ready;
    logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic wb_commit, wb_wen, wb_csr_wen, flush;
    logic id_stall, id_issue, sb_err;
    logic [1:0] stall_reason;
    logic [31:0] stall_cycles;

    ysyx_041461_hazard_scoreboard #(.CNT_W(CNT_W), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
        .id_csr_rd(id_csr_rd), .id_csr_wen(id_csr_wen), .exe_ready(exe_ready),
        .wb_commit(wb_commit), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_csr_wen(wb_csr_wen),
        .flush(flush), .id_stall(id_stall), .id_issue(id_issue), .stall_reason(stall_reason),
        .stall_cycles(stall_cycles), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: plain counts of outstanding writes.
    int m_cnt [32];
    int m_csr, m_inf;
    logic [31:0] m_sc;
    bit m_err;
    bit exp_stall, exp_issue;
    int exp_reason;

    typedef struct packed {logic [4:0] rd; logic wen; logic csrwen;} ent_t;
    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_csr = 0; m_inf = 0; m_sc = 0; m_err = 0;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_wen = 0; id_csr_rd = 0; id_csr_wen = 0; exe_ready = 1;
        wb_commit = 0; wb_rd = 0; wb_wen = 0; wb_csr_wen = 0; flush = 0;
    endtask

    task automatic set_id(input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit wen, input bit crd, input bit cwen);
        id_valid = 1; id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2); id_use_rs2 = u2;
        id_rd = 5'(rd); id_wen = wen; id_csr_rd = crd; id_csr_wen = cwen;
    endtask

    task automatic set_wb(input int rd, input bit wen, input bit cwen);
        wb_commit = 1; wb_rd = 5'(rd); wb_wen = wen; wb_csr_wen = cwen;
    endtask

    // Settle combinational outputs, then compare them with the model.
    task automatic settle();
        bit raw, csrh, st;
        #1;
        if (rst) model_reset();
        raw  = (id_use_rs1 && id_rs1 != 0 && m_cnt[id_rs1] > 0) ||
               (id_use_rs2 && id_rs2 != 0 && m_cnt[id_rs2] > 0);
        csrh = (id_csr_rd || id_csr_wen) && m_csr > 0;
        st   = (m_inf == MAX_INFLIGHT) ||
               (id_wen && id_rd != 0 && m_cnt[id_rd] == (1 << CNT_W) - 1);
        exp_stall  = rst || flush || (id_valid && (raw || csrh || st));
        exp_issue  = id_valid && !exp_stall && exe_ready;
        exp_reason = (rst || !id_valid) ? 0 : raw ? 1 : csrh ? 2 : st ? 3 : 0;
        chk("id_stall", 32'(id_stall), 32'(exp_stall));
        chk("id_issue", 32'(id_issue), 32'(exp_issue));
        chk("stall_reason", 32'(stall_reason), 32'(exp_reason));
        chk("stall_cycles", stall_cycles, m_sc);
        chk("sb_err", 32'(sb_err), 32'(m_err));
    endtask

    task automatic advance();
        if (!rst) begin
            if (id_valid && exp_stall) m_sc = m_sc + 32'd1;
            if (flush) begin
                foreach (m_cnt[i]) m_cnt[i] = 0;
                m_csr = 0; m_inf = 0;
            end else begin
                if (wb_commit) begin
                    if (wb_wen && wb_rd != 0) begin
                        if (m_cnt[wb_rd] == 0) m_err = 1; else m_cnt[wb_rd]--;
                    end
                    if (wb_csr_wen) begin
                        if (m_csr == 0) m_err = 1; else m_csr--;
                    end
                    if (m_inf == 0) m_err = 1; else m_inf--;
                end
                if (exp_issue) begin
                    if (id_wen && id_rd != 0) m_cnt[id_rd]++;
                    if (id_csr_wen) m_csr++;
                    m_inf++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    initial begin
        model_reset();
        idle();
        @(negedge clk);
        settle();
        chk("lit_reset_stall", 32'(id_stall), 32'd1);
        chk("lit_reset_issue", 32'(id_issue), 32'd0);
        advance();
        rst = 0;

        // Back-to-back RAW on x5, producer commits in the third stall cycle.
        idle(); set_id(0, 0, 0, 0, 5, 1, 0, 0); settle();
        chk("lit_raw_prod_issue", 32'(id_issue), 32'd1); advance();
        for (int c = 0; c < 3; c++) begin
            idle(); set_id(5, 1, 5, 1, 6, 1, 0, 0);
            if (c == 2) set_wb(5, 1, 0);
            settle();
            chk("lit_raw_reason", 32'(stall_reason), 32'd1);
            advance();
        end
        idle(); set_id(5, 1, 5, 1, 6, 1, 0, 0); settle();
        chk("lit_raw_release", 32'(id_issue), 32'd1);
        chk("lit_raw_cycles", stall_cycles, 32'd3); advance();
        idle(); set_wb(6, 1, 0); tick();

        // x0 as destination then source.
        idle(); set_id(0, 0, 0, 0, 0, 1, 0, 0); tick();
        idle(); set_id(0, 1, 0, 1, 0, 1, 0, 0); settle();
        chk("lit_x0_nostall", 32'(id_stall), 32'd0); advance();
        idle(); set_wb(0, 1, 0); tick();
        idle(); set_wb(0, 1, 0); settle();
        chk("lit_x0_noerr", 32'(sb_err), 32'd0); advance();

        // Window full.
        for (int r = 10; r < 13; r++) begin idle(); set_id(0, 0, 0, 0, r, 1, 0, 0); tick(); end
        idle(); set_id(0, 0, 0, 0, 13, 1, 0, 0); settle();
        chk("lit_full_reason", 32'(stall_reason), 32'd3); advance();
        idle(); set_id(0, 0, 0, 0, 13, 1, 0, 0); set_wb(10, 1, 0); tick();
        idle(); set_id(0, 0, 0, 0, 13, 1, 0, 0); settle();
        chk("lit_full_release", 32'(id_issue), 32'd1); advance();
        for (int r = 11; r < 14; r++) begin idle(); set_wb(r, 1, 0); tick(); end

        // Same-cycle issue and commit on x7.
        idle(); set_id(0, 0, 0, 0, 7, 1, 0, 0); tick();
        idle(); set_id(0, 0, 0, 0, 7, 1, 0, 0); set_wb(7, 1, 0); settle();
        chk("lit_x7_issue", 32'(id_issue), 32'd1); advance();
        idle(); set_id(7, 1, 0, 0, 0, 0, 0, 0); set_wb(7, 1, 0); settle();
        chk("lit_x7_still", 32'(stall_reason), 32'd1); advance();
        idle(); set_id(7, 1, 0, 0, 0, 0, 0, 0); tick();
        idle(); set_wb(0, 0, 0); tick();

        // CSR serialization and flush.
        idle(); set_id(0, 0, 0, 0, 0, 0, 1, 1); tick();
        idle(); set_id(0, 0, 0, 0, 8, 1, 1, 0); settle();
        chk("lit_csr_reason", 32'(stall_reason), 32'd2); advance();
        idle(); set_id(0, 0, 0, 0, 8, 1, 1, 0); flush = 1; settle();
        chk("lit_flush_issue", 32'(id_issue), 32'd0); advance();
        idle(); set_id(0, 0, 0, 0, 8, 1, 1, 0); settle();
        chk("lit_post_flush", 32'(id_issue), 32'd1); advance();
        idle(); flush = 1; tick();

        // Spurious commit on x9.
        idle(); set_wb(9, 1, 0); tick();
        idle(); set_id(9, 1, 9, 1, 0, 0, 0, 0); settle();
        chk("lit_spur_err", 32'(sb_err), 32'd1);
        chk("lit_spur_x9", 32'(id_stall), 32'd0); advance();
        idle(); flush = 1; tick();
        idle(); settle();
        chk("lit_err_sticky", 32'(sb_err), 32'd1); advance();
        idle(); rst = 1; tick(); rst = 0;
        idle(); settle();
        chk("lit_err_cleared", 32'(sb_err), 32'd0); advance();

        // Randomized traffic with in-order commits drawn from issued instructions.
        q.delete();
        for (int n = 0; n < 4000; n++) begin
            ent_t e;
            idle();
            id_valid   = $urandom_range(0, 3) != 0;
            id_rs1     = 5'($urandom_range(0, 6));
            id_rs2     = 5'($urandom_range(0, 6));
            id_use_rs1 = 1'($urandom_range(0, 1));
            id_use_rs2 = 1'($urandom_range(0, 1));
            id_rd      = 5'($urandom_range(0, 6));
            id_wen     = 1'($urandom_range(0, 1));
            id_csr_rd  = $urandom_range(0, 7) == 0;
            id_csr_wen = $urandom_range(0, 7) == 0;
            exe_ready  = $urandom_range(0, 4) != 0;
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                e = q.pop_front();
                set_wb(e.rd, e.wen && ($urandom_range(0, 19) != 0), e.csrwen);
            end else if ($urandom_range(0, 59) == 0) begin
                set_wb($urandom_range(0, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            flush = $urandom_range(0, 39) == 0;
            rst   = $urandom_range(0, 599) == 0;
            settle();
            if (rst || flush) q.delete();
            else if (exp_issue) q.push_back('{rd: id_rd, wen: id_wen, csrwen: id_csr_wen});
            advance();
            rst = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_041461_hazard_scoreboard.md
# ysyx_041461_hazard_scoreboard

Register/CSR write-back scoreboard and issue interlock for the ysyx_041461 in-order RV64 pipeline. It tracks in-flight writes to the 31 writable integer registers and to the CSR file, which are committed in the write-back stage. It stalls ID issue on RAW hazards, because no forwarding exists and all readers see only committed architectural state. It also stalls when the in-flight window is full, and it clears on a trap flush.

## Interface
Parameters:
- CNT_W, 2: width of each per-register pending counter; at most 2^CNT_W-1 outstanding writes per register.
- MAX_INFLIGHT, 3: maximum number of instructions issued but not yet committed or flushed.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a valid instruction
- id_rs1, id_rs2  in  5 each  source register indices
- id_use_rs1, id_use_rs2  in  1 each  instruction reads that source
- id_rd  in  5  destination index
- id_wen  in  1  instruction writes id_rd
- id_csr_rd  in  1  instruction reads the CSR file
- id_csr_wen  in  1  instruction writes the CSR file
- exe_ready  in  1  EXE accepts an instruction this cycle
- wb_commit  in  1  WB retires an instruction this cycle (valid and ready)
- wb_rd  in  5  retiring destination
- wb_wen  in  1  retiring instruction writes wb_rd (0 if trapped)
- wb_csr_wen  in  1  retiring instruction writes a CSR
- flush  in  1  trap/mret redirect taken in WB; kills all younger instructions
- id_stall  out  1  ID must hold (combinational)
- id_issue  out  1  id_valid & ~id_stall & exe_ready
- stall_reason  out  2  0 none, 1 RAW on GPR, 2 CSR busy, 3 window full/counter saturated
- stall_cycles  out  32  count of cycles with id_valid & id_stall
- sb_err  out  1  sticky; commit without a matching pending entry

## Operation
- State: cnt[1..31] (CNT_W bits each; index 0 does not exist), csr_cnt (CNT_W), inflight (clog2(MAX_INFLIGHT+1)), stall_cycles, sb_err.
- RAW: stall if (id_use_rs1 & id_rs1!=0 & cnt[id_rs1]!=0) or the same for rs2. Index 0 never stalls.
- CSR: stall if (id_csr_rd | id_csr_wen) & csr_cnt!=0. This serializes CSR ops, including mcycle/minstret reads.
- Structural: stall if inflight==MAX_INFLIGHT, or if id_wen & id_rd!=0 & cnt[id_rd]==all-ones.
- Priority for stall_reason: RAW(1) > CSR(2) > structural(3). The value is 0 whenever id_stall=0 or id_valid=0.
- flush=1 forces id_stall=1 and id_issue=0 in that cycle.
- Issue (id_issue=1): cnt[id_rd]+1 if id_wen & id_rd!=0; csr_cnt+1 if id_csr_wen; inflight+1.
- Commit (wb_commit=1): cnt[wb_rd]-1 if wb_wen & wb_rd!=0; csr_cnt-1 if wb_csr_wen; inflight-1.
- A commit that hits a zero counter leaves the counter at 0 (no underflow) and sets sb_err.
- Issue and commit in the same cycle apply both. If both target the same register, the net counter change is 0.
- Flush: at the next edge every cnt, csr_cnt and inflight goes to 0. Flush has priority over a simultaneous commit and issue. sb_err and stall_cycles are kept.
- Stall still holds in the cycle a write commits, because the register file updates on that edge. The dependent instruction issues in the following cycle.
- stall_cycles wraps modulo 2^32.

## Timing
- id_stall, id_issue and stall_reason are combinational from the registered state and the current inputs. There is no added latency.
- All counters update on posedge clk.
- Release latency: a dependent instruction issues exactly 1 cycle after the commit cycle of its producer.
- Reset: asynchronous and immediate. All counters are 0, inflight=0, stall_cycles=0, sb_err=0.
- While rst=1, id_stall=1, id_issue=0 and stall_reason=0.
- When reset is asserted mid-operation, all pending state is discarded with no stall-release glitch. The first issue after reset deassertion is possible on the first edge.

## Test plan
- Back-to-back RAW: issue addi x5, then add x6,x5,x5 with x5 committing 3 cycles later. Required: id_stall=1 and stall_reason=1 for 3 cycles; id_issue=1 on cycle 4; stall_cycles=3.
- x0 destination and source: issue writes to x0, then a read of x0. Required: no stall; cnt unchanged.
- Window full: MAX_INFLIGHT=3 independent issues with no commits, then a 4th. Required: stall_reason=3. One commit brings inflight to 2 and the 4th issues on the next cycle.
- Same-cycle issue and commit on x7 with cnt[x7]=1. Required: cnt[x7] stays 1 and the reader of x7 remains stalled.
- CSR serialization and flush: csrrw mtvec in flight, then csrr mepc in ID. Required: stall_reason=2. Asserting flush with a simultaneous issue gives id_issue=0, all counters 0 next cycle, and no stall afterwards.
- Spurious commit: wb_commit with wb_wen=1, wb_rd=9 and cnt[9]=0. Required: sb_err=1 stays set until reset; cnt[9] stays 0.
